// File: rtl/ex_muldiv_pkg.sv
// Shared operation codes, FSM state encoding and decode helpers for the
// ex_muldiv execute stage and its iterative multiply/divide engine.
package ex_muldiv_pkg;

    // Single-cycle ALU operations
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 5;
    localparam int ALU_SRL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_SLT  = 8;
    localparam int ALU_SLTU = 9;
    // Multi-cycle operations, served by the iterative engine
    localparam int ALU_MUL   = 10;
    localparam int ALU_MULHU = 11;
    localparam int ALU_DIVU  = 12;
    localparam int ALU_REMU  = 13;
    // Passes the registered immediate straight through (LUI-style)
    localparam int ALU_IMM   = 14;

    localparam int DEST_SRC_NONE = 0;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_RUN  = 2'd1,
        EX_DONE = 2'd2
    } ex_state_e;

    function automatic logic is_multicycle(input int op);
        return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    function automatic logic is_divide(input int op);
        return (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    // MULHU and REMU take their result from the upper half of the accumulator
    function automatic logic result_in_high(input int op);
        return (op == ALU_MULHU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide engine: one bit per clock,
// WORD_W iterations per operation, with a combinational done pulse.
module ex_muldiv_iter
    import ex_muldiv_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start_i,
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [WORD_W-1:0]   a_i,
    input  logic [WORD_W-1:0]   b_i,
    output logic                done_o,
    output logic [WORD_W-1:0]   result_o
);

    localparam int CNT_W = $clog2(WORD_W);

    logic                  run_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [2*WORD_W-1:0]   acc_q;
    logic [2*WORD_W-1:0]   acc_d;
    logic [WORD_W-1:0]     opnd_q;
    logic                  div_q;
    logic                  hi_sel_q;

    logic [WORD_W-1:0]     acc_hi;
    logic [WORD_W-1:0]     acc_lo;
    logic [WORD_W:0]       mul_sum;
    logic [WORD_W:0]       rem_shift;
    logic [WORD_W-1:0]     rem_sub;
    logic                  rem_ge;

    assign acc_hi = acc_q[2*WORD_W-1:WORD_W];
    assign acc_lo = acc_q[WORD_W-1:0];

    // Multiply: acc_lo holds the remaining multiplier bits, opnd_q the
    // multiplicand. Divide: acc_hi is the partial remainder, acc_lo shifts
    // the dividend out and the quotient in. A zero divisor naturally yields
    // an all-ones quotient and a remainder equal to the dividend.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : {(WORD_W+1){1'b0}});
        rem_shift = {acc_hi, acc_lo[WORD_W-1]};
        rem_ge    = rem_shift >= {1'b0, opnd_q};
        rem_sub   = rem_shift[WORD_W-1:0] - opnd_q;
        acc_d     = acc_q;
        if (div_q) begin
            if (rem_ge) begin
                acc_d = {rem_sub, acc_lo[WORD_W-2:0], 1'b1};
            end else begin
                acc_d = {rem_shift[WORD_W-1:0], acc_lo[WORD_W-2:0], 1'b0};
            end
        end else begin
            acc_d = {mul_sum, acc_lo[WORD_W-1:1]};
        end
    end

    assign done_o   = run_q && (cnt_q == CNT_W'(WORD_W - 1));
    assign result_o = hi_sel_q ? acc_d[2*WORD_W-1:WORD_W] : acc_d[WORD_W-1:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
            hi_sel_q <= 1'b0;
        end else if (start_i) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            div_q    <= is_divide(int'(op_i));
            hi_sel_q <= result_in_high(int'(op_i));
            if (is_divide(int'(op_i))) begin
                acc_q  <= {{WORD_W{1'b0}}, a_i};
                opnd_q <= b_i;
            end else begin
                acc_q  <= {{WORD_W{1'b0}}, b_i};
                opnd_q <= a_i;
            end
        end else if (run_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Execute stage: pipeline register plus single-cycle ALU, with an iterative
// multiply/divide engine that back-pressures upstream via o_busy.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int WORD_W     = 32,  // must be >= 4
    parameter int ADDR_W     = 32,
    parameter int INSTR_W    = 32,
    parameter int REG_IDX_W  = 5,
    parameter int ALU_OP_W   = 4,
    parameter int DEST_SRC_W = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  stall,
    input  logic [ADDR_W-1:0]     i_pc,
    input  logic [INSTR_W-1:0]    i_instr,
    input  logic [ALU_OP_W-1:0]   i_alu_op,
    input  logic [WORD_W-1:0]     i_alu_data1,
    input  logic [WORD_W-1:0]     i_alu_data2,
    input  logic [WORD_W-1:0]     i_imm,
    input  logic [DEST_SRC_W-1:0] i_dest_src,
    input  logic [REG_IDX_W-1:0]  i_dest_reg,
    output logic [ADDR_W-1:0]     o_pc,
    output logic [INSTR_W-1:0]    o_instr,
    output logic [DEST_SRC_W-1:0] o_dest_src,
    output logic [REG_IDX_W-1:0]  o_dest_reg,
    output logic [WORD_W-1:0]     o_alu_eval,
    output logic                  o_valid,
    output logic                  o_busy
);

    localparam int SHW = $clog2(WORD_W);
    localparam logic [DEST_SRC_W-1:0] DS_NONE = DEST_SRC_W'(DEST_SRC_NONE);

    logic [ADDR_W-1:0]     pc_q;
    logic [INSTR_W-1:0]    instr_q;
    logic [ALU_OP_W-1:0]   alu_op_q;
    logic [WORD_W-1:0]     data1_q;
    logic [WORD_W-1:0]     data2_q;
    logic [WORD_W-1:0]     imm_q;
    logic [DEST_SRC_W-1:0] dest_src_q;
    logic [REG_IDX_W-1:0]  dest_reg_q;
    logic [WORD_W-1:0]     result_q;
    ex_state_e             state_q;
    ex_state_e             state_d;

    logic                  busy;
    logic                  capture;
    logic                  iter_start;
    logic                  iter_done;
    logic [WORD_W-1:0]     iter_result;
    logic [WORD_W-1:0]     alu_out;
    logic [SHW-1:0]        shamt;

    assign busy       = (state_q == EX_RUN);
    assign capture    = !clr && !stall && !busy;
    assign iter_start = capture && is_multicycle(int'(i_alu_op));

    ex_muldiv_iter #(
        .WORD_W   (WORD_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_iter (
        .clk      (clk),
        .clr      (clr),
        .start_i  (iter_start),
        .op_i     (i_alu_op),
        .a_i      (i_alu_data1),
        .b_i      (i_alu_data2),
        .done_o   (iter_done),
        .result_o (iter_result)
    );

    // Single-cycle ALU on the registered operands
    assign shamt = data2_q[SHW-1:0];

    always_comb begin
        alu_out = '0;
        case (int'(alu_op_q))
            ALU_ADD:  alu_out = data1_q + data2_q;
            ALU_SUB:  alu_out = data1_q - data2_q;
            ALU_AND:  alu_out = data1_q & data2_q;
            ALU_OR:   alu_out = data1_q | data2_q;
            ALU_XOR:  alu_out = data1_q ^ data2_q;
            ALU_SLL:  alu_out = data1_q << shamt;
            ALU_SRL:  alu_out = data1_q >> shamt;
            ALU_SRA:  alu_out = WORD_W'($signed(data1_q) >>> shamt);
            ALU_SLT:  alu_out = {{(WORD_W-1){1'b0}}, $signed(data1_q) < $signed(data2_q)};
            ALU_SLTU: alu_out = {{(WORD_W-1){1'b0}}, data1_q < data2_q};
            ALU_IMM:  alu_out = imm_q;
            default:  alu_out = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EX_IDLE, EX_DONE: begin
                if (capture) begin
                    state_d = is_multicycle(int'(i_alu_op)) ? EX_RUN : EX_IDLE;
                end
            end
            EX_RUN: begin
                if (iter_done) begin
                    state_d = EX_DONE;
                end
            end
            default: state_d = EX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q       <= '0;
            instr_q    <= '0;
            alu_op_q   <= ALU_OP_W'(ALU_ADD);
            data1_q    <= '0;
            data2_q    <= '0;
            imm_q      <= '0;
            dest_src_q <= DS_NONE;
            dest_reg_q <= '0;
            result_q   <= '0;
            state_q    <= EX_IDLE;
        end else begin
            if (capture) begin
                pc_q       <= i_pc;
                instr_q    <= i_instr;
                alu_op_q   <= i_alu_op;
                data1_q    <= i_alu_data1;
                data2_q    <= i_alu_data2;
                imm_q      <= i_imm;
                dest_src_q <= i_dest_src;
                dest_reg_q <= i_dest_reg;
            end
            if (busy && iter_done) begin
                result_q <= iter_result;
            end
            state_q <= state_d;
        end
    end

    // While iterating, a bubble is presented downstream
    always_comb begin
        o_alu_eval = '0;
        o_dest_src = dest_src_q;
        o_valid    = 1'b1;
        o_busy     = 1'b0;
        case (state_q)
            EX_IDLE: o_alu_eval = alu_out;
            EX_DONE: o_alu_eval = result_q;
            EX_RUN: begin
                o_dest_src = DS_NONE;
                o_valid    = 1'b0;
                o_busy     = 1'b1;
            end
            default: o_alu_eval = '0;
        endcase
    end

    assign o_pc       = pc_q;
    assign o_instr    = instr_q;
    assign o_dest_reg = dest_reg_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: ALU path, multiply/divide,
// hold/stall, flush mid-operation and back-to-back multi-cycle ops.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        stall;
    logic [31:0] i_pc;
    logic [31:0] i_instr;
    logic [3:0]  i_alu_op;
    logic [31:0] i_alu_data1;
    logic [31:0] i_alu_data2;
    logic [31:0] i_imm;
    logic [1:0]  i_dest_src;
    logic [4:0]  i_dest_reg;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic [1:0]  o_dest_src;
    logic [4:0]  o_dest_reg;
    logic [31:0] o_alu_eval;
    logic        o_valid;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    ex_muldiv dut (
        .clk         (clk),
        .clr         (clr),
        .stall       (stall),
        .i_pc        (i_pc),
        .i_instr     (i_instr),
        .i_alu_op    (i_alu_op),
        .i_alu_data1 (i_alu_data1),
        .i_alu_data2 (i_alu_data2),
        .i_imm       (i_imm),
        .i_dest_src  (i_dest_src),
        .i_dest_reg  (i_dest_reg),
        .o_pc        (o_pc),
        .o_instr     (o_instr),
        .o_dest_src  (o_dest_src),
        .o_dest_reg  (o_dest_reg),
        .o_alu_eval  (o_alu_eval),
        .o_valid     (o_valid),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic present(input int op, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] ds, input logic [4:0] dr, input logic [31:0] pc);
        i_alu_op    = 4'(op);
        i_alu_data1 = a;
        i_alu_data2 = b;
        i_dest_src  = ds;
        i_dest_reg  = dr;
        i_pc        = pc;
        i_instr     = pc ^ 32'hA5A5_0000;
        i_imm       = 32'h0;
    endtask

    // Waits out the busy phase after a capture edge and checks the result
    task automatic wait_result(input string name, input logic [31:0] exp, input logic [1:0] exp_ds);
        int cyc = 0;
        int bub = 0;
        @(negedge clk);
        while (o_busy === 1'b1 && cyc < 100) begin
            if (o_dest_src !== 2'd0 || o_valid !== 1'b0 || o_alu_eval !== 32'h0) bub++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc !== 32) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected 32", name, cyc);
        end
        checks++;
        if (bub !== 0) begin
            errors++;
            $display("FAIL %s bubble: %0d busy cycles with dest_src/valid/eval not 0/0/0", name, bub);
        end
        checks++;
        if (o_valid !== 1'b1 || o_alu_eval !== exp || o_dest_src !== exp_ds) begin
            errors++;
            $display("FAIL %s result: got eval=%h valid=%b ds=%0d expected eval=%h valid=1 ds=%0d",
                     name, o_alu_eval, o_valid, o_dest_src, exp, exp_ds);
        end
        $display("txn %s: eval=%h after %0d busy cycles", name, o_alu_eval, cyc);
    endtask

    // Capture one multi-cycle op, then stall with a decoy ADD on the inputs
    task automatic run_mc(input string name, input int op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        present(op, a, b, 2'd1, 5'd9, 32'h0000_0400);
        @(posedge clk);
        #1;
        stall = 1'b1;
        present(ALU_ADD, 32'd1, 32'd1, 2'd2, 5'd7, 32'h0000_0200);
        wait_result(name, exp, 2'd1);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        stall = 1'b0;
        present(ALU_SUB, 32'd9, 32'd3, 2'd3, 5'd1, 32'h40);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_pc !== 32'h0 || o_instr !== 32'h0 || o_dest_reg !== 5'd0 || o_dest_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs: pc=%h instr=%h dr=%0d ds=%0d expected all 0", o_pc, o_instr, o_dest_reg, o_dest_src);
        end
        checks++;
        if (o_alu_eval !== 32'h0 || o_valid !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: eval=%h valid=%b busy=%b expected 0/1/0", o_alu_eval, o_valid, o_busy);
        end
        $display("txn reset: pc=%h eval=%h valid=%b busy=%b", o_pc, o_alu_eval, o_valid, o_busy);
        clr = 1'b0;
    endtask

    task automatic test_alu();
        present(ALU_ADD, 32'd5, 32'd7, 2'd1, 5'd3, 32'h100);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_alu_eval !== 32'd12 || o_valid !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL alu_add: eval=%h valid=%b busy=%b expected 0000000c/1/0", o_alu_eval, o_valid, o_busy);
        end
        checks++;
        if (o_pc !== 32'h100 || o_instr !== 32'hA5A5_0100 || o_dest_src !== 2'd1 || o_dest_reg !== 5'd3) begin
            errors++;
            $display("FAIL alu_regs: pc=%h instr=%h ds=%0d dr=%0d expected 100/a5a50100/1/3", o_pc, o_instr, o_dest_src, o_dest_reg);
        end
        $display("txn add 5+7: eval=%h", o_alu_eval);
        present(ALU_SUB, 32'd3, 32'd5, 2'd1, 5'd4, 32'h104);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_alu_eval !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL alu_sub: eval=%h expected fffffffe", o_alu_eval);
        end
        $display("txn sub 3-5: eval=%h", o_alu_eval);
    endtask

    task automatic test_mul();
        run_mc("mul", ALU_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
        stall = 1'b0;
        run_mc("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        stall = 1'b0;
    endtask

    task automatic test_div();
        run_mc("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14);
        stall = 1'b0;
        run_mc("remu", ALU_REMU, 32'd100, 32'd7, 32'd2);
        stall = 1'b0;
        run_mc("divu_by0", ALU_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF);
        stall = 1'b0;
        run_mc("remu_by0", ALU_REMU, 32'd9, 32'd0, 32'd9);
        stall = 1'b0;
    endtask

    task automatic test_hold();
        int held = 0;
        run_mc("hold_divu", ALU_DIVU, 32'd100, 32'd7, 32'd14);
        checks++;
        if (o_pc !== 32'h0000_0400) begin
            errors++;
            $display("FAIL hold_no_capture: pc=%h expected 00000400", o_pc);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_alu_eval === 32'd14 && o_valid === 1'b1 && o_busy === 1'b0) held++;
        end
        checks++;
        if (held !== 5) begin
            errors++;
            $display("FAIL hold_stall: result held %0d of 5 cycles", held);
        end
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_alu_eval !== 32'd2 || o_pc !== 32'h0000_0200 || o_dest_src !== 2'd2 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: eval=%h pc=%h ds=%0d busy=%b expected 2/00000200/2/0",
                     o_alu_eval, o_pc, o_dest_src, o_busy);
        end
        $display("txn hold release: eval=%h pc=%h", o_alu_eval, o_pc);
    endtask

    task automatic test_flush();
        present(ALU_DIVU, 32'd1000, 32'd3, 2'd1, 5'd5, 32'h300);
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        present(ALU_ADD, 32'd0, 32'd0, 2'd0, 5'd0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b1 || o_dest_src !== 2'd0 || o_pc !== 32'h0) begin
            errors++;
            $display("FAIL flush: busy=%b valid=%b ds=%0d pc=%h expected 0/1/0/0", o_busy, o_valid, o_dest_src, o_pc);
        end
        $display("txn flush: busy=%b pc=%h", o_busy, o_pc);
        clr = 1'b0;
        run_mc("mul_after_flush", ALU_MUL, 32'd1234, 32'd5678, 32'h006A_E9BC);
        stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        present(ALU_DIVU, 32'd100, 32'd7, 2'd1, 5'd6, 32'h500);
        @(posedge clk);
        #1;
        present(ALU_MUL, 32'h0001_0003, 32'h0000_0005, 2'd3, 5'd8, 32'h504);
        wait_result("b2b_divu", 32'd14, 2'd1);
        @(posedge clk);
        #1;
        stall = 1'b1;
        wait_result("b2b_mul", 32'h0005_000F, 2'd3);
        checks++;
        if (o_pc !== 32'h504 || o_dest_reg !== 5'd8) begin
            errors++;
            $display("FAIL b2b_regs: pc=%h dr=%0d expected 00000504/8", o_pc, o_dest_reg);
        end
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_div();
        test_hold();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
